// File: rtl/multicycle_control_pkg.sv
// Shared state/kind types and opcode, funct and ALU constants for multicycle_control.
// The TRAP state is only present when MULTICYCLE_CTRL_TRAP_EN is defined.
package multicycle_control_pkg;

`ifdef MULTICYCLE_CTRL_TRAP_EN
   typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb, StTrap} state_e;
`else
   typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb} state_e;
`endif

   typedef enum logic [1:0] {KindAlu, KindLoad, KindStore, KindIllegal} kind_e;

   localparam int unsigned OP_ALU_DEF   = 5;
   localparam int unsigned OP_LOAD_DEF  = 6;
   localparam int unsigned OP_STORE_DEF = 7;

   localparam logic [5:0] FUNCT_ADD = 6'd32;
   localparam logic [5:0] FUNCT_SUB = 6'd34;
   localparam logic [5:0] FUNCT_AND = 6'd36;
   localparam logic [5:0] FUNCT_OR  = 6'd37;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_OR  = 2'd3;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode/funct decoder: instruction kind, ALU code, mux selects and legality.
module ctrl_decode
   import multicycle_control_pkg::*;
#(
   parameter int unsigned ALU_CTRL_W = 2,
   parameter int unsigned OP_ALU     = OP_ALU_DEF,
   parameter int unsigned OP_LOAD    = OP_LOAD_DEF,
   parameter int unsigned OP_STORE   = OP_STORE_DEF
) (
   input  logic [5:0]            i_op,
   input  logic [5:0]            i_funct,
   output kind_e                 o_kind,
   output logic [ALU_CTRL_W-1:0] o_alu_control,
   output logic                  o_mux1_ctrl,
   output logic                  o_mux2_ctrl,
   output logic                  o_legal
);

   logic [1:0] w_alu_code;
   logic       w_funct_ok;

   always_comb begin
      w_alu_code = ALU_ADD;
      w_funct_ok = 1'b1;
      unique case (i_funct)
         FUNCT_ADD: w_alu_code = ALU_ADD;
         FUNCT_SUB: w_alu_code = ALU_SUB;
         FUNCT_AND: w_alu_code = ALU_AND;
         FUNCT_OR:  w_alu_code = ALU_OR;
         default:   w_funct_ok = 1'b0;
      endcase
   end

   // Memory ops compute base + immediate and write back memory data.
   always_comb begin
      o_kind        = KindIllegal;
      o_alu_control = '0;
      o_mux1_ctrl   = 1'b0;
      o_mux2_ctrl   = 1'b0;
      if (i_op == 6'(OP_ALU) && w_funct_ok) begin
         o_kind        = KindAlu;
         o_alu_control = ALU_CTRL_W'(w_alu_code);
      end else if (i_op == 6'(OP_LOAD)) begin
         o_kind      = KindLoad;
         o_mux1_ctrl = 1'b1;
         o_mux2_ctrl = 1'b1;
      end else if (i_op == 6'(OP_STORE)) begin
         o_kind      = KindStore;
         o_mux1_ctrl = 1'b1;
         o_mux2_ctrl = 1'b1;
      end
   end

   assign o_legal = (o_kind != KindIllegal);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: IDLE/DECODE/EXEC/MEM/WB with bounded memory wait, registered outputs.
// Define MULTICYCLE_CTRL_TRAP_EN to latch illegal instructions and memory timeouts in TRAP.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned ALU_CTRL_W  = 2,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned OP_ALU      = OP_ALU_DEF,
   parameter int unsigned OP_LOAD     = OP_LOAD_DEF,
   parameter int unsigned OP_STORE    = OP_STORE_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_instr_valid,
   input  logic [31:0]           i_instr,
   output logic                  o_instr_ready,
   input  logic                  i_mem_ready,
   output logic [4:0]            o_rs,
   output logic [4:0]            o_rt,
   output logic [4:0]            o_rd,
   output logic [ALU_CTRL_W-1:0] o_alu_control,
   output logic                  o_mux1_ctrl,
   output logic                  o_mux2_ctrl,
   output logic                  o_wr,
   output logic                  o_ce,
   output logic                  o_reg_we,
   output logic                  o_mem_err,
   output logic                  o_illegal,
   output logic [31:0]           o_output_controle
);

   state_e                r_state, w_state_d;
   kind_e                 r_kind, w_kind_d;
   logic [31:0]           r_ir;
   logic [7:0]            r_wait_cnt, w_cnt_d, w_cnt_inc;
   logic                  r_instr_ready, w_ready_d;
   logic [4:0]            r_rs, r_rt, r_rd, w_rs_d, w_rt_d, w_rd_d;
   logic [ALU_CTRL_W-1:0] r_alu, w_alu_d;
   logic                  r_mux1, r_mux2, w_mux1_d, w_mux2_d;
   logic                  r_wr, r_ce, r_reg_we, r_mem_err, r_illegal;
   logic                  w_wr_d, w_ce_d, w_reg_we_d, w_mem_err_d, w_illegal_d;
   logic                  w_accept;

   kind_e                 w_dec_kind;
   logic [ALU_CTRL_W-1:0] w_dec_alu;
   logic                  w_dec_mux1, w_dec_mux2, w_dec_legal;
   logic                  w_unused_shamt;

   ctrl_decode #(
      .ALU_CTRL_W (ALU_CTRL_W),
      .OP_ALU     (OP_ALU),
      .OP_LOAD    (OP_LOAD),
      .OP_STORE   (OP_STORE)
   ) u_decode (
      .i_op          (r_ir[31:26]),
      .i_funct       (r_ir[5:0]),
      .o_kind        (w_dec_kind),
      .o_alu_control (w_dec_alu),
      .o_mux1_ctrl   (w_dec_mux1),
      .o_mux2_ctrl   (w_dec_mux2),
      .o_legal       (w_dec_legal)
   );

   assign w_unused_shamt = ^r_ir[10:6];
   assign w_accept       = (r_state == StIdle) && r_instr_ready && i_instr_valid;
   assign w_cnt_inc      = r_wait_cnt + 8'd1;

   always_comb begin
      w_state_d   = r_state;
      w_kind_d    = r_kind;
      w_cnt_d     = r_wait_cnt;
      w_mem_err_d = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_accept) w_state_d = StDecode;
         end
         StDecode: begin
            w_kind_d = w_dec_kind;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            w_state_d = w_dec_legal ? StExec : StTrap;
`else
            w_state_d = StExec;
`endif
         end
         StExec: begin
            unique case (r_kind)
               KindAlu:             w_state_d = StWb;
               KindLoad, KindStore: begin
                  w_state_d = StMem;
                  w_cnt_d   = '0;
               end
               default:             w_state_d = StIdle;
            endcase
         end
         StMem: begin
            // A ready response wins over a timeout landing in the same cycle.
            if (i_mem_ready) begin
               w_state_d = (r_kind == KindLoad) ? StWb : StIdle;
            end else begin
               w_cnt_d = w_cnt_inc;
               if (w_cnt_inc == 8'(MEM_TIMEOUT)) begin
                  w_mem_err_d = 1'b1;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                  w_state_d = StTrap;
`else
                  w_state_d = StIdle;
`endif
               end
            end
         end
         StWb:    w_state_d = StIdle;
`ifdef MULTICYCLE_CTRL_TRAP_EN
         StTrap:  w_state_d = StTrap;
`endif
         default: w_state_d = StIdle;
      endcase

      // Moore outputs for the state being entered on this edge.
      w_ready_d   = (w_state_d == StIdle);
      w_ce_d      = (w_state_d == StMem);
      w_wr_d      = (w_state_d == StMem) && (w_kind_d == KindStore);
      w_reg_we_d  = (w_state_d == StWb);
      w_illegal_d = (w_kind_d == KindIllegal) && (w_state_d != StIdle)
                    && (w_state_d != StDecode);

      w_rs_d   = '0;
      w_rt_d   = '0;
      w_rd_d   = '0;
      w_alu_d  = '0;
      w_mux1_d = 1'b0;
      w_mux2_d = 1'b0;
      if (r_state == StDecode) begin
         if (w_dec_legal) begin
            w_rs_d   = r_ir[25:21];
            w_rt_d   = r_ir[20:16];
            w_rd_d   = (w_dec_kind == KindAlu) ? r_ir[15:11] : r_ir[20:16];
            w_alu_d  = w_dec_alu;
            w_mux1_d = w_dec_mux1;
            w_mux2_d = w_dec_mux2;
         end
      end else if (w_state_d inside {StExec, StMem, StWb}) begin
         w_rs_d   = r_rs;
         w_rt_d   = r_rt;
         w_rd_d   = r_rd;
         w_alu_d  = r_alu;
         w_mux1_d = r_mux1;
         w_mux2_d = r_mux2;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_kind        <= KindAlu;
         r_ir          <= '0;
         r_wait_cnt    <= '0;
         r_instr_ready <= 1'b0;
         r_rs          <= '0;
         r_rt          <= '0;
         r_rd          <= '0;
         r_alu         <= '0;
         r_mux1        <= 1'b0;
         r_mux2        <= 1'b0;
         r_wr          <= 1'b0;
         r_ce          <= 1'b0;
         r_reg_we      <= 1'b0;
         r_mem_err     <= 1'b0;
         r_illegal     <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_kind        <= w_kind_d;
         r_wait_cnt    <= w_cnt_d;
         r_instr_ready <= w_ready_d;
         r_rs          <= w_rs_d;
         r_rt          <= w_rt_d;
         r_rd          <= w_rd_d;
         r_alu         <= w_alu_d;
         r_mux1        <= w_mux1_d;
         r_mux2        <= w_mux2_d;
         r_wr          <= w_wr_d;
         r_ce          <= w_ce_d;
         r_reg_we      <= w_reg_we_d;
         r_mem_err     <= w_mem_err_d;
         r_illegal     <= w_illegal_d;
         if (w_accept) r_ir <= i_instr;
      end
   end

   assign o_instr_ready     = r_instr_ready;
   assign o_rs              = r_rs;
   assign o_rt              = r_rt;
   assign o_rd              = r_rd;
   assign o_alu_control     = r_alu;
   assign o_mux1_ctrl       = r_mux1;
   assign o_mux2_ctrl       = r_mux2;
   assign o_wr              = r_wr;
   assign o_ce              = r_ce;
   assign o_reg_we          = r_reg_we;
   assign o_mem_err         = r_mem_err;
   assign o_illegal         = r_illegal;
   assign o_output_controle = {r_rs, r_rt, r_rd, r_alu[1:0], r_mux1, r_mux2, r_wr, r_ce, 11'b0};

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into an expected per-cycle output
// trace from the instruction-class rules, then driven and compared cycle by cycle.
module tb_multicycle_control;

   localparam int T = 15;

   typedef struct packed {
      logic       rdy;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [1:0] alu;
      logic       m1;
      logic       m2;
      logic       wr;
      logic       ce;
      logic       we;
      logic       err;
      logic       ill;
   } obs_t;

   logic        clk;
   logic        i_rst, i_instr_valid, i_mem_ready;
   logic [31:0] i_instr;
   logic        o_instr_ready, o_mux1_ctrl, o_mux2_ctrl, o_wr, o_ce, o_reg_we;
   logic        o_mem_err, o_illegal;
   logic [4:0]  o_rs, o_rt, o_rd;
   logic [1:0]  o_alu_control;
   logic [31:0] o_output_controle;

   int   n_checks = 0;
   int   n_errors = 0;
   obs_t exp_q[$];
   bit   exp_trap;

   multicycle_control #(
      .ALU_CTRL_W  (2),
      .MEM_TIMEOUT (T),
      .OP_ALU      (5),
      .OP_LOAD     (6),
      .OP_STORE    (7)
   ) dut (
      .i_clk             (clk),
      .i_rst             (i_rst),
      .i_instr_valid     (i_instr_valid),
      .i_instr           (i_instr),
      .o_instr_ready     (o_instr_ready),
      .i_mem_ready       (i_mem_ready),
      .o_rs              (o_rs),
      .o_rt              (o_rt),
      .o_rd              (o_rd),
      .o_alu_control     (o_alu_control),
      .o_mux1_ctrl       (o_mux1_ctrl),
      .o_mux2_ctrl       (o_mux2_ctrl),
      .o_wr              (o_wr),
      .o_ce              (o_ce),
      .o_reg_we          (o_reg_we),
      .o_mem_err         (o_mem_err),
      .o_illegal         (o_illegal),
      .o_output_controle (o_output_controle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_obs(input string tag, input obs_t e);
      obs_t        o;
      logic [31:0] word;
      o    = {o_instr_ready, o_rs, o_rt, o_rd, o_alu_control, o_mux1_ctrl, o_mux2_ctrl,
              o_wr, o_ce, o_reg_we, o_mem_err, o_illegal};
      word = {e.rs, e.rt, e.rd, e.alu, e.m1, e.m2, e.wr, e.ce, 11'b0};
      check({tag, " outs"}, 32'(o), 32'(e));
      check({tag, " ctrl_word"}, o_output_controle, word);
   endtask

   // Expected outputs for cycles 1..N after the accepting edge (w = mem_ready low cycles).
   function automatic void build_trace(input logic [31:0] ins, input int w);
      obs_t       f, z, c;
      logic [5:0] op, funct;
      int         code;
      bit         is_alu, is_ld, is_st;
      exp_q.delete();
      exp_trap = 1'b0;
      op    = ins[31:26];
      funct = ins[5:0];
      case (funct)
         6'd32:   code = 0;
         6'd34:   code = 1;
         6'd36:   code = 2;
         6'd37:   code = 3;
         default: code = -1;
      endcase
      is_alu = (op == 6'd5) && (code >= 0);
      is_ld  = (op == 6'd6);
      is_st  = (op == 6'd7);
      z = '0;
      f = '0;
      f.rs  = ins[25:21];
      f.rt  = ins[20:16];
      f.rd  = is_alu ? ins[15:11] : ins[20:16];
      f.alu = is_alu ? code[1:0] : 2'd0;
      f.m1  = !is_alu;
      f.m2  = !is_alu;
      exp_q.push_back(z);
      if (!(is_alu || is_ld || is_st)) begin
         c = z;
         c.ill = 1'b1;
`ifdef MULTICYCLE_CTRL_TRAP_EN
         repeat (3) exp_q.push_back(c);
         exp_trap = 1'b1;
`else
         exp_q.push_back(c);
         c = z;
         c.rdy = 1'b1;
         exp_q.push_back(c);
`endif
         return;
      end
      exp_q.push_back(f);
      if (is_alu) begin
         c = f;
         c.we = 1'b1;
         exp_q.push_back(c);
      end else begin
         c = f;
         c.ce = 1'b1;
         c.wr = is_st;
         if (w < T) begin
            repeat (w + 1) exp_q.push_back(c);
            if (is_ld) begin
               c = f;
               c.we = 1'b1;
               exp_q.push_back(c);
            end
         end else begin
            repeat (T) exp_q.push_back(c);
            c = z;
            c.err = 1'b1;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            exp_q.push_back(c);
            c.err = 1'b0;
            repeat (2) exp_q.push_back(c);
            exp_trap = 1'b1;
`else
            c.rdy = 1'b1;
            exp_q.push_back(c);
`endif
            return;
         end
      end
      c = z;
      c.rdy = 1'b1;
      exp_q.push_back(c);
   endfunction

   task automatic do_reset(input string tag);
      obs_t idle;
      idle     = '0;
      idle.rdy = 1'b1;
      i_rst         = 1'b1;
      i_instr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_obs({tag, " in_reset"}, '0);
      i_rst = 1'b0;
      @(posedge clk);
      #1;
      check_obs({tag, " idle_after_reset"}, idle);
   endtask

   // Starts in an IDLE cycle; offers the instruction and walks its whole expected trace.
   task automatic run_instr(input string tag, input logic [31:0] ins, input int w,
                            input int rst_at, input bit hold);
      int   n;
      obs_t idle;
      idle     = '0;
      idle.rdy = 1'b1;
      build_trace(ins, w);
      n = exp_q.size();
      i_instr_valid = 1'b1;
      i_instr       = ins;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         #1;
         check_obs($sformatf("%s c%0d", tag, k), exp_q[k-1]);
         i_instr       = $urandom;
         i_instr_valid = (k == n) ? 1'b0 : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
         i_mem_ready   = (k < 3) ? 1'($urandom_range(0, 1)) : (k >= 3 + w);
         if (k == rst_at) begin
            i_rst = 1'b1;
            @(posedge clk);
            #1;
            check_obs({tag, " in_rst"}, '0);
            i_rst         = 1'b0;
            i_instr_valid = 1'b0;
            @(posedge clk);
            #1;
            check_obs({tag, " after_rst"}, idle);
            exp_trap = 1'b0;
            return;
         end
      end
   endtask

   task automatic exec(input string tag, input logic [31:0] ins, input int w, input bit hold);
      run_instr(tag, ins, w, 0, hold);
      if (exp_trap) do_reset({tag, " trap"});
   endtask

   initial begin
      logic [31:0] ins;
      logic [5:0]  functs [4];
      int          sel, w;
      functs = '{6'd32, 6'd34, 6'd36, 6'd37};
      i_rst         = 1'b1;
      i_instr_valid = 1'b0;
      i_instr       = '0;
      i_mem_ready   = 1'b0;
      do_reset("reset");

      exec("add",   {6'd5, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32}, 0, 0);
      exec("sub",   {6'd5, 5'd9, 5'd10, 5'd11, 5'd0, 6'd34}, 2, 0);
      exec("and",   {6'd5, 5'd31, 5'd0, 5'd17, 5'd4, 6'd36}, 0, 0);
      exec("or",    {6'd5, 5'd6, 5'd7, 5'd8, 5'd0, 6'd37}, 1, 0);
      exec("load_w3",       {6'd6, 5'd1, 5'd4, 16'h0010}, 3, 0);
      exec("load_w0",       {6'd6, 5'd2, 5'd5, 16'hfff0}, 0, 0);
      exec("store_timeout", {6'd7, 5'd3, 5'd6, 16'h0004}, 255, 0);
      exec("store_last",    {6'd7, 5'd3, 5'd6, 16'h0008}, T - 1, 0);
      exec("load_timeout",  {6'd6, 5'd8, 5'd9, 16'h0000}, T, 0);
      exec("bad_op",        {6'd9, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32}, 0, 0);
      exec("bad_funct",     {6'd5, 5'd1, 5'd2, 5'd3, 5'd0, 6'd33}, 0, 0);
      run_instr("rst_mem",  {6'd6, 5'd1, 5'd4, 16'h0020}, 255, 4, 1'b0);
      exec("b2b_add",   {6'd5, 5'd4, 5'd5, 5'd6, 5'd0, 6'd32}, 0, 1);
      exec("b2b_load",  {6'd6, 5'd7, 5'd8, 16'h1234}, 2, 1);
      exec("b2b_store", {6'd7, 5'd9, 5'd10, 16'h0002}, 0, 1);

      for (int it = 0; it < 40; it++) begin
         sel = $urandom_range(0, 9);
         ins = $urandom;
         w   = $urandom_range(0, 18);
         if (sel < 4) begin
            ins[31:26] = 6'd5;
            if (sel < 3) ins[5:0] = functs[$urandom_range(0, 3)];
         end else if (sel < 6) begin
            ins[31:26] = 6'd6;
         end else if (sel < 8) begin
            ins[31:26] = 6'd7;
         end
         exec($sformatf("rand%0d", it), ins, w, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
